// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: registers encoder requests and presents one interrupt at a time over valid/ack/eoi.
// Define IRQ_DISPATCH_TMR_EN to triplicate state, captured bus/chan and wait counter with majority voting.
module irq_dispatch #(
  parameter int TIMEOUT_CYC = 16,
  parameter int MISS_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pa,
  input  logic              pb,
  input  logic              pc,
  input  logic [3:0]        chan,
  output logic              irq_valid,
  output logic [1:0]        irq_bus,
  output logic [3:0]        irq_chan,
  input  logic              irq_ack,
  input  logic              eoi,
  output logic              timeout,
  output logic [MISS_W-1:0] miss_cnt,
  input  logic              miss_clr,
  output logic              tmr_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2, DONE = 2'd3} state_t;

  // Everything that is protected by redundancy lives in one packed word.
  typedef struct packed {
    state_t     st;
    logic [1:0] bus;
    logic [3:0] chan;
    logic [7:0] cnt;
  } core_t;

  core_t             core0_q;
  core_t             voted;
  core_t             nxt;
  logic              tmo_q;
  logic              tmo_nxt;
  logic [MISS_W-1:0] miss_q;
  logic              any_req;

  function automatic core_t vote(input core_t a, input core_t b, input core_t c);
    return core_t'((a & b) | (a & c) | (b & c));
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign any_req = pa | pb | pc;

  // State register (single copy or triplicated, each copy reloads the voted next value)
`ifdef IRQ_DISPATCH_TMR_EN
  core_t core1_q;
  core_t core2_q;

  assign voted   = vote(core0_q, core1_q, core2_q);
  assign tmr_err = (core0_q != core1_q) || (core0_q != core2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      core0_q <= '0;
      core1_q <= '0;
      core2_q <= '0;
    end else begin
      core0_q <= nxt;
      core1_q <= nxt;
      core2_q <= nxt;
    end
  end
`else
  assign voted   = core0_q;
  assign tmr_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) core0_q <= '0;
    else     core0_q <= nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= tmo_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || miss_clr)                   miss_q <= '0;
    else if (voted.st != IDLE && any_req)  miss_q <= sat_inc(miss_q);
  end

  // Next-state logic
  always_comb begin
    nxt     = voted;
    tmo_nxt = 1'b0;
    case (voted.st)
      IDLE: begin
        nxt.bus  = 2'b00;
        nxt.chan = 4'h0;
        nxt.cnt  = 8'd0;
        if (any_req) begin
          nxt.st   = REQ;
          nxt.bus  = pa ? 2'b01 : (pb ? 2'b10 : 2'b11);
          nxt.chan = chan;
        end
      end
      REQ: begin
        // An ack in the expiry cycle takes precedence over the timeout.
        if (irq_ack) begin
          nxt.st = SERV;
        end else if (voted.cnt == 8'(TIMEOUT_CYC - 1)) begin
          nxt.st   = IDLE;
          nxt.bus  = 2'b00;
          nxt.chan = 4'h0;
          nxt.cnt  = 8'd0;
          tmo_nxt  = 1'b1;
        end else begin
          nxt.cnt = voted.cnt + 8'd1;
        end
      end
      SERV: begin
        if (eoi) nxt.st = DONE;
      end
      DONE: begin
        nxt.st   = IDLE;
        nxt.bus  = 2'b00;
        nxt.chan = 4'h0;
        nxt.cnt  = 8'd0;
      end
      default: nxt = '0;
    endcase
  end

  // Output decode
  always_comb begin
    irq_valid = (voted.st == REQ);
    irq_bus   = (voted.st == IDLE) ? 2'b00 : voted.bus;
    irq_chan  = (voted.st == IDLE) ? 4'h0  : voted.chan;
  end

  assign timeout  = tmo_q;
  assign miss_cnt = miss_q;

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Sits directly downstream of the 27-channel interrupt priority encoder. It registers the encoder's bus-request flags and channel code, and presents one interrupt at a time to the host over a valid/ack/eoi handshake.

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, meaning cycles irq_valid may wait for ack (range 2..255).
REQ-002 Parameter MISS_W, default 8, meaning width of missed-request counter.
REQ-003 Port clk, input, 1, sole clock; all flops rising-edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port pa / pb / pc, input, 1 each, encoder bus-A/B/C request flags, combinational from upstream.
REQ-006 Port chan, input, 4, encoder channel code; opaque, passed through unmodified.
REQ-007 Port irq_valid, output, 1, interrupt pending to host.
REQ-008 Port irq_bus, output, 2, captured source bus: 01=A, 10=B, 11=C, 00=none.
REQ-009 Port irq_chan, output, 4, captured channel code.
REQ-010 Port irq_ack, input, 1, host accepts pending interrupt.
REQ-011 Port eoi, input, 1, host end-of-interrupt.
REQ-012 Port timeout, output, 1, one-cycle pulse when ack is not received in time.
REQ-013 Port miss_cnt, output, MISS_W, saturating count of request cycles seen while busy.
REQ-014 Port miss_clr, input, 1, synchronous clear of miss_cnt.
REQ-015 Port tmr_err, output, 1, one-cycle pulse on redundant-copy disagreement.

Function
REQ-016 State machine SHALL have states IDLE, REQ, SERV, DONE.
REQ-017 IDLE: if any of pa/pb/pc=1 at the edge, SHALL capture bus (priority pa>pb>pc) and chan, then enter REQ; capture-to-irq_valid latency is 1 cycle.
REQ-018 REQ: irq_valid=1, irq_bus and irq_chan held stable; irq_ack=1 SHALL move to SERV and drop irq_valid on the next cycle.
REQ-019 REQ: wait counter SHALL clear on entry and increment each cycle without ack. At count TIMEOUT_CYC-1 with no ack, SHALL go to IDLE and pulse timeout for that next cycle. irq_valid is therefore high exactly TIMEOUT_CYC cycles.
REQ-020 Ack arriving in the same cycle the timeout expires SHALL win: go to SERV, no timeout pulse.
REQ-021 SERV: irq_bus and irq_chan held; eoi=1 SHALL go to DONE; irq_ack ignored.
REQ-022 DONE: exactly one cycle, no capture, then IDLE; a request present in DONE is counted as a miss.
REQ-023 eoi outside SERV, and irq_ack outside REQ, SHALL be ignored.
REQ-024 irq_bus/irq_chan SHALL read 00/0000 in IDLE.
REQ-025 miss_cnt SHALL increment by 1 each cycle that state != IDLE and (pa|pb|pc)=1, saturating at 2^MISS_W-1.
REQ-026 miss_clr and increment in the same cycle SHALL give 0 (clear wins).

Reset
REQ-027 rst SHALL force IDLE, irq_valid=0, irq_bus=00, irq_chan=0, timeout=0, tmr_err=0, miss_cnt=0, wait counter=0.
REQ-028 rst asserted mid-REQ or mid-SERV SHALL abandon the interrupt with no timeout pulse; the first capture is possible in the cycle after rst deasserts.

Configuration
REQ-029 Macro IRQ_DISPATCH_TMR_EN defined: state, captured bus/chan and wait counter SHALL be triplicated with bitwise majority voting. Every copy SHALL reload the voted value each cycle. tmr_err SHALL pulse 1 in any cycle the three copies disagree.
REQ-030 Macro undefined: single-copy registers; tmr_err tied 0; port list and all other behaviour identical.

Verification
REQ-031 pb=1, chan=4'h5 in IDLE -> next cycle irq_valid=1, irq_bus=10, irq_chan=5; ack -> SERV; eoi -> DONE, then IDLE two cycles after eoi.
REQ-032 pa=pc=1 simultaneously -> irq_bus=01.
REQ-033 TIMEOUT_CYC=16, no ack -> irq_valid high 16 cycles, timeout=1 on the 17th, state IDLE; ack on the 16th cycle -> SERV, timeout stays 0.
REQ-034 pa held high through REQ+SERV+DONE of 20 cycles -> miss_cnt=20; MISS_W=4 with 20 cycles -> 15; miss_clr during increment -> 0.
REQ-035 rst pulsed while in SERV -> next cycle all outputs at reset values, no timeout pulse.
REQ-036 IRQ_DISPATCH_TMR_EN defined, force one state copy to a wrong value for one cycle -> tmr_err=1 for one cycle, outputs unaffected, copies re-converge next cycle.
